// File: rtl/single_cycle_mips_cpu.sv
// single_cycle_mips_cpu
//   Single-cycle 32-bit MIPS-I subset core. Every clock fetches, decodes,
//   executes and retires one instruction. Holds the PC, a 32x32 register
//   file, the ALU, the control decoder, the instruction memory (instance
//   mem_data) and the data memory (instance mem). Program and data images
//   are preloaded into the memory arrays; state is observed hierarchically.
// Ports:
//   clk   : system clock, all state updates on the rising edge
//   reset : synchronous, active-high; pc <= RESET_PC, registers cleared,
//           no memory write while asserted

// mips_mem
//   Word-addressed 32-bit RAM: asynchronous read, write on rising edge.
//   The storage array has no reset so images can be preloaded.
// Ports:
//   clk   : clock
//   we    : write enable
//   addr  : word index (wraps modulo depth)
//   wdata : write data
//   rdata : combinational read data
module mips_mem #(
  parameter int WORDS = 1024,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem_data [0:WORDS-1];

  always_ff @(posedge clk) begin
    if (we) mem_data[addr] <= wdata;
  end

  assign rdata = mem_data[addr];
endmodule

module single_cycle_mips_cpu #(
  parameter int          IMEM_WORDS = 1024,
  parameter int          DMEM_WORDS = 1024,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input logic clk,
  input logic reset
);
  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03,
                         OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08,
                         OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B,
                         OP_ANDI  = 6'h0C, OP_ORI  = 6'h0D, OP_XORI = 6'h0E,
                         OP_LUI   = 6'h0F, OP_LW   = 6'h23, OP_SW   = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL  = 6'h02, FN_SRA  = 6'h03,
                         FN_JR  = 6'h08, FN_ADD  = 6'h20, FN_ADDU = 6'h21,
                         FN_SUB = 6'h22, FN_SUBU = 6'h23, FN_AND  = 6'h24,
                         FN_OR  = 6'h25, FN_XOR  = 6'h26, FN_NOR  = 6'h27,
                         FN_SLT = 6'h2A, FN_SLTU = 6'h2B;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_op_e;

  typedef enum logic [1:0] {DST_RD, DST_RT, DST_RA} dst_e;
  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_e;

  logic [31:0] pc;
  logic [31:0] regs [0:31];

  logic [31:0] instr;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm16;
  logic [31:0] imm_sext, imm_zext, imm_val;

  alu_op_e     alu_op;
  dst_e        dst;
  wb_e         wb_sel;
  logic        use_imm, zext_imm, reg_we, mem_we;
  logic        is_beq, is_bne, is_jmp, is_jr;

  logic [31:0] rs_val, rt_val, alu_b, alu_res;
  logic [31:0] dmem_rdata, wb_data;
  logic [4:0]  waddr;
  logic [31:0] pc_plus4, br_target, j_target, pc_next;

  // ---------------- fetch ----------------
  mips_mem #(.WORDS(IMEM_WORDS)) mem_data (
    .clk   (clk),
    .we    (1'b0),
    .addr  (pc[IAW+1:2]),
    .wdata (32'h0),
    .rdata (instr)
  );

  assign opcode   = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign shamt    = instr[10:6];
  assign funct    = instr[5:0];
  assign imm16    = instr[15:0];
  assign imm_sext = {{16{imm16[15]}}, imm16};
  assign imm_zext = {16'h0, imm16};

  // ---------------- decode ----------------
  always_comb begin
    alu_op   = ALU_ADD;
    dst      = DST_RD;
    wb_sel   = WB_ALU;
    use_imm  = 1'b0;
    zext_imm = 1'b0;
    reg_we   = 1'b0;
    mem_we   = 1'b0;
    is_beq   = 1'b0;
    is_bne   = 1'b0;
    is_jmp   = 1'b0;
    is_jr    = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        reg_we = 1'b1;
        case (funct)
          FN_ADD, FN_ADDU: alu_op = ALU_ADD;
          FN_SUB, FN_SUBU: alu_op = ALU_SUB;
          FN_AND:          alu_op = ALU_AND;
          FN_OR:           alu_op = ALU_OR;
          FN_XOR:          alu_op = ALU_XOR;
          FN_NOR:          alu_op = ALU_NOR;
          FN_SLT:          alu_op = ALU_SLT;
          FN_SLTU:         alu_op = ALU_SLTU;
          FN_SLL:          alu_op = ALU_SLL;
          FN_SRL:          alu_op = ALU_SRL;
          FN_SRA:          alu_op = ALU_SRA;
          FN_JR: begin
            reg_we = 1'b0;
            is_jr  = 1'b1;
          end
          default:         reg_we = 1'b0;  // unsupported funct: NOP
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        use_imm = 1'b1; reg_we = 1'b1; dst = DST_RT;
      end
      OP_SLTI: begin
        use_imm = 1'b1; reg_we = 1'b1; dst = DST_RT; alu_op = ALU_SLT;
      end
      OP_SLTIU: begin
        // immediate is sign-extended, then compared unsigned
        use_imm = 1'b1; reg_we = 1'b1; dst = DST_RT; alu_op = ALU_SLTU;
      end
      OP_ANDI: begin
        use_imm = 1'b1; zext_imm = 1'b1; reg_we = 1'b1; dst = DST_RT;
        alu_op = ALU_AND;
      end
      OP_ORI: begin
        use_imm = 1'b1; zext_imm = 1'b1; reg_we = 1'b1; dst = DST_RT;
        alu_op = ALU_OR;
      end
      OP_XORI: begin
        use_imm = 1'b1; zext_imm = 1'b1; reg_we = 1'b1; dst = DST_RT;
        alu_op = ALU_XOR;
      end
      OP_LUI: begin
        use_imm = 1'b1; reg_we = 1'b1; dst = DST_RT; alu_op = ALU_LUI;
      end
      OP_LW: begin
        use_imm = 1'b1; reg_we = 1'b1; dst = DST_RT; wb_sel = WB_MEM;
      end
      OP_SW: begin
        use_imm = 1'b1; mem_we = 1'b1;
      end
      OP_BEQ: is_beq = 1'b1;
      OP_BNE: is_bne = 1'b1;
      OP_J:   is_jmp = 1'b1;
      OP_JAL: begin
        is_jmp = 1'b1; reg_we = 1'b1; dst = DST_RA; wb_sel = WB_PC4;
      end
      default: ;  // unsupported opcode: NOP
    endcase
  end

  // ---------------- register read ----------------
  // $0 is forced to zero so it reads 0 even before the first reset
  assign rs_val = (rs == 5'd0) ? 32'h0 : regs[rs];
  assign rt_val = (rt == 5'd0) ? 32'h0 : regs[rt];

  // ---------------- execute ----------------
  assign imm_val = zext_imm ? imm_zext : imm_sext;
  assign alu_b   = use_imm ? imm_val : rt_val;

  always_comb begin
    alu_res = 32'h0;
    case (alu_op)
      ALU_ADD:  alu_res = rs_val + alu_b;
      ALU_SUB:  alu_res = rs_val - alu_b;
      ALU_AND:  alu_res = rs_val & alu_b;
      ALU_OR:   alu_res = rs_val | alu_b;
      ALU_XOR:  alu_res = rs_val ^ alu_b;
      ALU_NOR:  alu_res = ~(rs_val | alu_b);
      ALU_SLT:  alu_res = {31'h0, $signed(rs_val) < $signed(alu_b)};
      ALU_SLTU: alu_res = {31'h0, rs_val < alu_b};
      ALU_SLL:  alu_res = rt_val << shamt;
      ALU_SRL:  alu_res = rt_val >> shamt;
      ALU_SRA:  alu_res = $unsigned($signed(rt_val) >>> shamt);
      ALU_LUI:  alu_res = {imm16, 16'h0};
      default:  alu_res = 32'h0;
    endcase
  end

  // ---------------- data memory ----------------
  // write is suppressed during reset so an aborted store never commits
  mips_mem #(.WORDS(DMEM_WORDS)) mem (
    .clk   (clk),
    .we    (mem_we && !reset),
    .addr  (alu_res[DAW+1:2]),
    .wdata (rt_val),
    .rdata (dmem_rdata)
  );

  // ---------------- write-back ----------------
  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    wb_data = alu_res;
    case (wb_sel)
      WB_MEM:  wb_data = dmem_rdata;
      WB_PC4:  wb_data = pc_plus4;
      default: wb_data = alu_res;
    endcase
  end

  always_comb begin
    waddr = rd;
    case (dst)
      DST_RT:  waddr = rt;
      DST_RA:  waddr = 5'd31;
      default: waddr = rd;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
    end else if (reg_we && waddr != 5'd0) begin
      regs[waddr] <= wb_data;
    end
  end

  // ---------------- next PC ----------------
  assign br_target = pc_plus4 + {imm_sext[29:0], 2'b00};
  assign j_target  = {pc_plus4[31:28], instr[25:0], 2'b00};

  always_comb begin
    pc_next = pc_plus4;
    if ((is_beq && rs_val == rt_val) || (is_bne && rs_val != rt_val))
      pc_next = br_target;
    else if (is_jmp)
      pc_next = j_target;
    else if (is_jr)
      pc_next = rs_val;
  end

  always_ff @(posedge clk) begin
    if (reset) pc <= RESET_PC;
    else       pc <= pc_next;
  end
endmodule

// File: tb/tb_single_cycle_mips_cpu.sv
// Self-checking bench for single_cycle_mips_cpu. Programs are encoded here,
// written into the memory arrays hierarchically, and expectations are queued
// in a scoreboard that is drained when the DUT reaches the checked state.
module tb_single_cycle_mips_cpu;
  logic clk;
  logic reset;

  single_cycle_mips_cpu dut (
    .clk   (clk),
    .reset (reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int K_REG = 0, K_MEM = 1, K_PC = 2;

  typedef struct {
    string       tag;
    int          kind;
    int          idx;
    logic [31:0] exp;
  } sb_t;

  sb_t         sb_q[$];
  logic [31:0] prog[$];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int kind, input int idx);
    case (kind)
      K_REG:   return dut.regs[idx];
      K_MEM:   return dut.mem.mem_data[idx];
      default: return dut.pc;
    endcase
  endfunction

  task automatic push(input string tag, input int kind, input int idx, input logic [31:0] v);
    sb_t e;
    e.tag = tag; e.kind = kind; e.idx = idx; e.exp = v;
    sb_q.push_back(e);
  endtask

  task automatic pop1();
    sb_t e;
    e = sb_q.pop_front();
    chk(e.tag, observe(e.kind, e.idx), e.exp);
  endtask

  task automatic drain();
    while (sb_q.size() > 0) pop1();
  endtask

  // instruction encoders
  function automatic logic [31:0] r_i(input int rs, input int rt, input int rd, input int sh, input int fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction
  function automatic logic [31:0] i_i(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction
  function automatic logic [31:0] j_i(input int op, input int tgt);
    return {6'(op), 26'(tgt)};
  endfunction

  localparam logic [31:0] HALT = 32'h1000_FFFF;  // beq $0,$0,-1

  task automatic load_prog();
    for (int i = 0; i < 1024; i++) dut.mem_data.mem_data[i] = 32'h0;
    for (int i = 0; i < prog.size(); i++) dut.mem_data.mem_data[i] = prog[i];
  endtask

  // called #1 after an edge; releases #1 after the third reset edge
  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic run_to(input string tag, input logic [31:0] halt_pc, input int max_cyc);
    for (int c = 0; c < max_cyc && dut.pc !== halt_pc; c++) begin
      @(posedge clk);
      #1;
    end
    chk(tag, dut.pc, halt_pc);
  endtask

  int arr[16];
  int tmp;

  initial begin
    reset = 1'b1;

    // ---- reset and PC sequencing into a self-loop at 0x20 ----
    prog = {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, HALT};
    load_prog();
    for (int k = 0; k < 3; k++) push("pc_in_reset", K_PC, 0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1 pop1();
    end
    reset = 1'b0;
    for (int k = 1; k <= 11; k++)
      push("pc_step", K_PC, 0, (4 * k < 32) ? 32'(4 * k) : 32'h20);
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk);
      #1 pop1();
    end
    for (int r = 0; r < 32; r++) push("reg_after_reset", K_REG, r, 32'h0);
    drain();

    // ---- ALU ----
    prog = {
      i_i(8, 0, 1, 5),            // addi $1,$0,5
      i_i(8, 0, 2, -3),           // addi $2,$0,-3
      r_i(1, 2, 3, 0, 6'h20),     // add  $3,$1,$2
      r_i(2, 1, 4, 0, 6'h2A),     // slt  $4,$2,$1
      r_i(2, 1, 5, 0, 6'h2B),     // sltu $5,$2,$1
      i_i(8, 0, 0, 7),            // addi $0,$0,7
      r_i(1, 2, 6, 0, 6'h22),     // sub  $6,$1,$2
      r_i(1, 2, 7, 0, 6'h27),     // nor  $7,$1,$2
      r_i(0, 2, 8, 1, 6'h03),     // sra  $8,$2,1
      r_i(0, 2, 9, 28, 6'h02),    // srl  $9,$2,28
      r_i(0, 1, 10, 4, 6'h00),    // sll  $10,$1,4
      i_i(12, 2, 11, 16'hFFFF),   // andi $11,$2,0xFFFF
      i_i(11, 1, 12, -1),         // sltiu $12,$1,-1
      i_i(14, 1, 13, 16'h8000),   // xori $13,$1,0x8000
      i_i(10, 2, 14, -2),         // slti $14,$2,-2
      HALT
    };
    load_prog();
    do_reset();
    push("add",   K_REG, 3,  32'd2);
    push("slt",   K_REG, 4,  32'd1);
    push("sltu",  K_REG, 5,  32'd0);
    push("r0",    K_REG, 0,  32'd0);
    push("sub",   K_REG, 6,  32'd8);
    push("nor",   K_REG, 7,  32'h2);
    push("sra",   K_REG, 8,  32'hFFFF_FFFE);
    push("srl",   K_REG, 9,  32'hF);
    push("sll",   K_REG, 10, 32'h50);
    push("andi",  K_REG, 11, 32'h0000_FFFD);
    push("sltiu", K_REG, 12, 32'd1);
    push("xori",  K_REG, 13, 32'h8005);
    push("slti",  K_REG, 14, 32'd1);
    run_to("alu_halt", 32'h3C, 100);
    drain();

    // ---- load/store, address wrap, ignored low bits ----
    dut.mem.mem_data[1]  = 32'h0;
    dut.mem.mem_data[2]  = 32'hDEAD_BEEF;
    dut.mem.mem_data[12] = 32'h0;
    prog = {
      i_i(15, 0, 1, 16'h1234),    // lui $1,0x1234
      i_i(13, 1, 1, 16'h5678),    // ori $1,$1,0x5678
      i_i(43, 0, 1, 48),          // sw  $1,48($0)
      i_i(35, 0, 2, 48),          // lw  $2,48($0)
      i_i(43, 0, 1, 16'h1004),    // sw  $1,0x1004($0) -> wraps to word 1
      i_i(35, 0, 3, 50),          // lw  $3,50($0)
      HALT
    };
    load_prog();
    do_reset();
    push("sw_word12", K_MEM, 12, 32'h1234_5678);
    push("lw",        K_REG, 2,  32'h1234_5678);
    push("sw_wrap",   K_MEM, 1,  32'h1234_5678);
    push("lw_lowbit", K_REG, 3,  32'h1234_5678);
    run_to("ls_halt", 32'h18, 100);
    drain();

    // reset arriving while a store is being fetched must not commit it
    dut.mem_data.mem_data[6] = i_i(43, 0, 1, 8);  // sw $1,8($0)
    reset = 1'b1;
    @(posedge clk);
    #1;
    push("rst_no_store", K_MEM, 2, 32'hDEAD_BEEF);
    push("rst_reg1",     K_REG, 1, 32'h0);
    push("rst_pc",       K_PC,  0, 32'h0);
    drain();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    push("sw_after_rst", K_MEM, 2, 32'h1234_5678);
    drain();

    // ---- branches and jumps ----
    prog = '{default: 32'h0};
    for (int i = 0; i < 18; i++) prog.push_back(32'h0);
    prog[0]  = i_i(8, 0, 1, 7);   // 0x00 addi $1,$0,7
    prog[1]  = i_i(8, 0, 2, 7);   // 0x04 addi $2,$0,7
    prog[2]  = j_i(3, 32'h10);    // 0x08 jal 0x40
    prog[3]  = i_i(5, 1, 2, 5);   // 0x0C bne $1,$2,5 (not taken)
    prog[4]  = i_i(4, 1, 2, 2);   // 0x10 beq $1,$2,2 -> 0x1C
    prog[5]  = i_i(8, 0, 3, 1);   // 0x14 skipped
    prog[6]  = i_i(8, 0, 3, 2);   // 0x18 skipped
    prog[7]  = j_i(2, 32'h9);     // 0x1C j 0x24
    prog[8]  = i_i(8, 0, 3, 3);   // 0x20 skipped
    prog[9]  = HALT;              // 0x24
    prog[16] = i_i(8, 0, 4, 9);   // 0x40 addi $4,$0,9
    prog[17] = r_i(31, 0, 0, 0, 6'h08);  // 0x44 jr $31
    load_prog();
    do_reset();
    push("br_pc", K_PC, 0, 32'h04);
    push("br_pc", K_PC, 0, 32'h08);
    push("jal_pc", K_PC, 0, 32'h40);
    push("br_pc", K_PC, 0, 32'h44);
    push("jr_pc", K_PC, 0, 32'h0C);
    push("bne_nt_pc", K_PC, 0, 32'h10);
    push("beq_t_pc", K_PC, 0, 32'h1C);
    push("j_pc", K_PC, 0, 32'h24);
    push("loop_pc", K_PC, 0, 32'h24);
    for (int k = 0; k < 9; k++) begin
      @(posedge clk);
      #1 pop1();
    end
    push("jal_ra",  K_REG, 31, 32'h0C);
    push("skipped", K_REG, 3,  32'h0);
    push("jal_sub", K_REG, 4,  32'd9);
    drain();

    // ---- system: insertion sort of 16 signed words at word 12 ----
    for (int i = 0; i < 16; i++) arr[i] = int'($urandom_range(0, 400)) - 200;
    arr[9] = arr[5];
    arr[15] = -2147483647;
    for (int i = 0; i < 16; i++) dut.mem.mem_data[12 + i] = 32'(arr[i]);
    dut.mem.mem_data[11] = 32'h5A5A_0011;
    dut.mem.mem_data[28] = 32'hA5A5_0028;
    for (int i = 0; i < 15; i++)
      for (int j = 0; j < 15 - i; j++)
        if (arr[j] > arr[j + 1]) begin
          tmp = arr[j]; arr[j] = arr[j + 1]; arr[j + 1] = tmp;
        end
    prog = {
      i_i(8, 0, 1, 52),           // 0  addi $1,$0,52
      i_i(8, 0, 2, 48 + 64),      // 1  addi $2,$0,112
      i_i(4, 1, 2, 13),           // 2  beq  $1,$2,done
      i_i(35, 1, 3, 0),           // 3  lw   $3,0($1)
      i_i(8, 1, 4, -4),           // 4  addi $4,$1,-4
      i_i(10, 4, 5, 48),          // 5  slti $5,$4,48
      i_i(5, 5, 0, 6),            // 6  bne  $5,$0,ins
      i_i(35, 4, 6, 0),           // 7  lw   $6,0($4)
      r_i(3, 6, 5, 0, 6'h2A),     // 8  slt  $5,$3,$6
      i_i(4, 5, 0, 3),            // 9  beq  $5,$0,ins
      i_i(43, 4, 6, 4),           // 10 sw   $6,4($4)
      i_i(8, 4, 4, -4),           // 11 addi $4,$4,-4
      i_i(4, 0, 0, -8),           // 12 beq  $0,$0,inner
      i_i(43, 4, 3, 4),           // 13 sw   $3,4($4)
      i_i(8, 1, 1, 4),            // 14 addi $1,$1,4
      i_i(4, 0, 0, -14),          // 15 beq  $0,$0,outer
      HALT                        // 16 0x40
    };
    load_prog();
    do_reset();
    for (int i = 0; i < 16; i++) push($sformatf("sort_%0d", i), K_MEM, 12 + i, 32'(arr[i]));
    push("sort_below", K_MEM, 11, 32'h5A5A_0011);
    push("sort_above", K_MEM, 28, 32'hA5A5_0028);
    run_to("sort_halt", 32'h40, 20000);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
